ps2_rx_fifo: RTL and testbench
==============================

# ps2_rx_fifo

Parametrised PS/2 device-to-host receiver with glitch-filtered clock, explicit frame FSM, frame timeout and a configurable-depth scan-code FIFO. It replaces the fixed 8-entry keyboard receiver in the lab7 keyboard path. It adds per-error sticky flags, a fill level and drop-on-full overflow, so no queued code is ever overwritten. It feeds the scan-code decoder and display logic in the same clock domain.

## Interface
- DEPTH_LOG2, 3: FIFO depth = 2**DEPTH_LOG2 entries, minimum 1.
- FILTER_LEN, 4: consecutive equal synchronized samples required to accept a ps2_clk level change, minimum 2.
- TIMEOUT_CYC, 2000: clk cycles without a filtered falling edge before an open frame is abandoned.
- clk  in  1  system clock.
- clrn  in  1  reset, synchronous, active-low.
- ps2_clk  in  1  raw PS/2 clock, asynchronous.
- ps2_data  in  1  raw PS/2 data, asynchronous.
- nextdata_n  in  1  active-low pop; ignored when FIFO empty.
- clr_err  in  1  high for one cycle clears overflow, parity_err and frame_err.
- data  out  8  scan code at FIFO head; valid while ready=1.
- ready  out  1  FIFO non-empty.
- level  out  DEPTH_LOG2+1  current entry count, 0..2**DEPTH_LOG2.
- overflow  out  1  sticky: a good frame was dropped because the FIFO was full.
- parity_err  out  1  sticky: a frame with even parity over data+parity was discarded.
- frame_err  out  1  sticky: bad stop bit or timeout.

## Operation
- ps2_clk and ps2_data each pass a 2-FF synchronizer.
- Filtered clock (reset value 1) takes a new value once the last FILTER_LEN synchronized samples all equal it.
- fall_stb: one-cycle pulse on a filtered 1->0 transition. Synchronized ps2_data is sampled only on fall_stb.
- FSM states and transitions, all on fall_stb:
  - IDLE: sample 0 -> DATA with bit counter 0. Sample 1 is ignored.
  - DATA: shift LSB-first. After the 8th bit -> PARITY.
  - PARITY: store parity bit -> STOP.
  - STOP, sample 1 and odd parity over data+parity: push to FIFO, or set overflow if full. -> IDLE.
  - STOP, sample 1 and parity even: set parity_err, no push. -> IDLE.
  - STOP, sample 0: set frame_err, no push. -> IDLE.
- Timeout: in any non-IDLE state, a counter counts cycles since the last fall_stb. At TIMEOUT_CYC it sets frame_err, discards the partial frame and forces IDLE. The counter is cleared in IDLE.
- FIFO: circular buffer with DEPTH_LOG2-bit pointers that wrap modulo depth. level tracks occupancy separately, so full and empty are unambiguous.
- Pop: with nextdata_n=0 and level>0, r_ptr increments and level decrements.
- Push and pop in the same cycle:
  - Both are performed and level is unchanged.
  - This holds when full too: the push is accepted, with no overflow.
- Pop when empty: no effect.
- Sticky flags: set has priority over a same-cycle clr_err.
- Reset mid-frame: FSM to IDLE, partial frame discarded, FIFO emptied.

## Timing
- Reset values: ready=0, level=0, overflow=0, parity_err=0, frame_err=0, FSM=IDLE, pointers 0, filtered clock 1. data is don't-care while ready=0.
- fall_stb asserts FILTER_LEN+2 clk cycles after a clean ps2_clk fall (2 synchronizer stages, then FILTER_LEN stable samples).
- Push latency: ready/level/data update on the clk edge after the fall_stb of the stop bit.
- data is combinational from fifo[r_ptr]. The new head is visible in the cycle after a pop.
- Error flags set on the clk edge after the causing fall_stb or timeout expiry.

## Structure
- Package ps2_pkg:
  - FSM state enum {IDLE, DATA, PARITY, STOP}.
  - Constant SCAN_W=8.
  - Default parameter constants.
- Sub-module ps2_sync_filter: 2-FF synchronizers for both lines, FILTER_LEN filter on the clock, outputs fall_stb and data_s.
- FSM, timeout counter and FIFO stay in ps2_rx_fifo.

## Test plan
- Clean frame for 0x1C (start 0, bits, parity 0, stop 1) -> ready=1, data=0x1C, level=1. Pop -> ready=0, level=0.
- Frame 0x1C with parity bit 1 -> parity_err=1, level=0. clr_err -> flag 0.
- 9 good frames 0x01..0x09 with no pops, DEPTH_LOG2=3 -> level=8, overflow=1. Pops return 0x01..0x08 in order.
- Full FIFO, pop asserted in the same cycle as the 9th push -> level stays 8, overflow=0. Tail entry is the new code.
- ps2_clk low glitch of FILTER_LEN-1 cycles mid-frame -> no extra bit shifted. The frame still decodes correctly.
- Truncated frame (start + 4 bits, then idle) -> after TIMEOUT_CYC frame_err=1, level=0. Following frame 0xF0 is received intact. clrn low mid-frame -> all outputs return to reset values.

Source files
------------

// File: rtl/ps2_rx_fifo_pkg.sv
// Shared types and defaults for the PS/2 receive path.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_t;

  localparam int SCAN_W          = 8;
  localparam int DEF_DEPTH_LOG2  = 3;
  localparam int DEF_FILTER_LEN  = 4;
  localparam int DEF_TIMEOUT_CYC = 2000;

  // PS/2 frames use odd parity: the XOR over data and parity bit must be 1.
  function automatic logic odd_parity(input logic [SCAN_W-1:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_rx_fifo_sync_filter.sv
// Synchronizes both PS/2 lines and debounces the clock line into a
// single-cycle falling-edge strobe.
module ps2_sync_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = DEF_FILTER_LEN
) (
  input  logic clk,
  input  logic clrn,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic fall_stb,
  output logic data_s
);

  logic [1:0]            clk_sync;
  logic [1:0]            data_sync;
  logic [FILTER_LEN-1:0] hist;
  logic [FILTER_LEN-1:0] hist_next;
  logic                  clk_flt;

  assign hist_next = {hist[FILTER_LEN-2:0], clk_sync[1]};
  assign data_s    = data_sync[1];

  // The filtered level only moves once the whole history window agrees,
  // so pulses shorter than FILTER_LEN cycles never reach the frame FSM.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      hist      <= '1;
      clk_flt   <= 1'b1;
      fall_stb  <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      hist      <= hist_next;
      fall_stb  <= 1'b0;
      if (&hist_next) begin
        clk_flt <= 1'b1;
      end else if (~|hist_next) begin
        clk_flt  <= 1'b0;
        fall_stb <= clk_flt;
      end
    end
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: frame FSM with timeout feeding a
// drop-on-full scan-code FIFO, plus sticky error flags.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH_LOG2  = DEF_DEPTH_LOG2,
  parameter int FILTER_LEN  = DEF_FILTER_LEN,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                clk,
  input  logic                clrn,
  input  logic                ps2_clk,
  input  logic                ps2_data,
  input  logic                nextdata_n,
  input  logic                clr_err,
  output logic [SCAN_W-1:0]   data,
  output logic                ready,
  output logic [DEPTH_LOG2:0] level,
  output logic                overflow,
  output logic                parity_err,
  output logic                frame_err
);

  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int LVL_W  = DEPTH_LOG2 + 1;
  localparam int TCNT_W = $clog2(TIMEOUT_CYC + 1);

  logic              fall_stb;
  logic              data_s;
  ps2_state_t        state;
  logic [2:0]        bit_cnt;
  logic [SCAN_W-1:0] shift;
  logic              par_bit;
  logic [TCNT_W-1:0] tcnt;

  logic [SCAN_W-1:0]     fifo [DEPTH];
  logic [DEPTH_LOG2-1:0] w_ptr;
  logic [DEPTH_LOG2-1:0] r_ptr;

  logic stop_fall;
  logic good_frame;
  logic bad_parity;
  logic bad_stop;
  logic timeout;
  logic full;
  logic pop;
  logic push;
  logic drop;

  ps2_sync_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_sync_filter (
    .clk     (clk),
    .clrn    (clrn),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .fall_stb(fall_stb),
    .data_s  (data_s)
  );

  assign stop_fall  = fall_stb && (state == STOP);
  assign good_frame = stop_fall && data_s && odd_parity(shift, par_bit);
  assign bad_parity = stop_fall && data_s && !odd_parity(shift, par_bit);
  assign bad_stop   = stop_fall && !data_s;
  assign timeout    = (state != IDLE) && !fall_stb &&
                      (tcnt == TCNT_W'(TIMEOUT_CYC - 1));

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a
  // new code when the consumer is popping at that moment.
  assign full = (level == LVL_W'(DEPTH));
  assign pop  = !nextdata_n && (level != '0);
  assign push = good_frame && (!full || pop);
  assign drop = good_frame && full && !pop;

  assign ready = (level != '0);
  assign data  = fifo[r_ptr];

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shift   <= '0;
      par_bit <= 1'b0;
      tcnt    <= '0;
    end else begin
      if (state == IDLE || fall_stb) begin
        tcnt <= '0;
      end else begin
        tcnt <= tcnt + 1'b1;
      end

      if (timeout) begin
        state <= IDLE;
      end else if (fall_stb) begin
        unique case (state)
          IDLE: begin
            if (!data_s) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shift   <= {data_s, shift[SCAN_W-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) begin
              state <= PARITY;
            end
          end
          PARITY: begin
            par_bit <= data_s;
            state   <= STOP;
          end
          STOP: begin
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      w_ptr <= '0;
      r_ptr <= '0;
      level <= '0;
    end else begin
      if (push) begin
        w_ptr <= w_ptr + 1'b1;
      end
      if (pop) begin
        r_ptr <= r_ptr + 1'b1;
      end
      if (push && !pop) begin
        level <= level + 1'b1;
      end else if (pop && !push) begin
        level <= level - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo[w_ptr] <= shift;
    end
  end

  // A new error event wins over a clear arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      overflow   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
      if (bad_parity) begin
        parity_err <= 1'b1;
      end else if (clr_err) begin
        parity_err <= 1'b0;
      end
      if (bad_stop || timeout) begin
        frame_err <= 1'b1;
      end else if (clr_err) begin
        frame_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Scoreboard bench for ps2_rx_fifo: drives PS/2 frames bit by bit and
// compares popped scan codes and status flags against a reference queue.
module tb_ps2_rx_fifo;
  localparam int DEPTH_LOG2  = 3;
  localparam int DEPTH       = 1 << DEPTH_LOG2;
  localparam int FILTER_LEN  = 4;
  localparam int TIMEOUT_CYC = 2000;
  localparam int HALF        = 20;

  logic                clk;
  logic                clrn;
  logic                ps2_clk;
  logic                ps2_data;
  logic                nextdata_n;
  logic                clr_err;
  logic [7:0]          data;
  logic                ready;
  logic [DEPTH_LOG2:0] level;
  logic                overflow;
  logic                parity_err;
  logic                frame_err;

  int checks;
  int errors;
  int model_level;
  logic [7:0] exp_q[$];

  ps2_rx_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk       (clk),
    .clrn      (clrn),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .nextdata_n(nextdata_n),
    .clr_err   (clr_err),
    .data      (data),
    .ready     (ready),
    .level     (level),
    .overflow  (overflow),
    .parity_err(parity_err),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Sends nbits bits of a frame. glitch_bit injects a short low pulse in
  // that bit's high phase; pop_at_stop pops exactly on the stop-bit push edge.
  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                            input int nbits, input int glitch_bit, input bit pop_at_stop,
                            output logic [7:0] popped);
    logic [10:0] bits;
    bits   = {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
    popped = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      for (int j = 0; j < HALF; j++) begin
        if (i == glitch_bit && j == 5) ps2_clk = 1'b0;
        if (i == glitch_bit && j == 5 + FILTER_LEN - 1) ps2_clk = 1'b1;
        tick(1);
      end
      ps2_clk = 1'b0;
      for (int j = 0; j < HALF; j++) begin
        if (pop_at_stop && i == 10 && j == FILTER_LEN + 2) begin
          popped     = data;
          nextdata_n = 1'b0;
        end
        if (pop_at_stop && i == 10 && j == FILTER_LEN + 3) nextdata_n = 1'b1;
        tick(1);
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    tick(HALF);
  endtask

  task automatic pop_one(output logic [7:0] val);
    val        = data;
    nextdata_n = 1'b0;
    tick(1);
    nextdata_n = 1'b1;
    if (model_level > 0) model_level--;
  endtask

  task automatic pulse_clr_err();
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    tick(1);
  endtask

  task automatic send_good(input logic [7:0] d);
    logic [7:0] unused;
    send_frame(d, 1'b0, 1'b0, 11, -1, 1'b0, unused);
    if (model_level < DEPTH) begin
      exp_q.push_back(d);
      model_level++;
    end
  endtask

  task automatic test_reset();
    clrn = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; nextdata_n = 1'b1; clr_err = 1'b0;
    tick(5);
    checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %0b expected 0", ready); end
    checks++; if (level !== '0) begin errors++; $display("[TB] FAIL reset_level: got %0d expected 0", level); end
    checks++; if ({overflow, parity_err, frame_err} !== 3'b000) begin
      errors++; $display("[TB] FAIL reset_flags: got %b expected 000", {overflow, parity_err, frame_err});
    end
    clrn = 1'b1;
    tick(3);
    model_level = 0;
  endtask

  task automatic test_clean_frame();
    logic [7:0] got;
    send_good(8'h1C);
    checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL clean_ready: got %0b expected 1", ready); end
    checks++; if (level !== 4'(model_level)) begin errors++; $display("[TB] FAIL clean_level: got %0d expected %0d", level, model_level); end
    pop_one(got);
    checks++; if (got !== exp_q[0]) begin errors++; $display("[TB] FAIL clean_data: got %02h expected %02h", got, exp_q[0]); end
    void'(exp_q.pop_front());
    checks++; if (ready !== 1'b0 || level !== '0) begin
      errors++; $display("[TB] FAIL clean_after_pop: got ready=%0b level=%0d expected ready=0 level=0", ready, level);
    end
  endtask

  task automatic test_frame_errors();
    logic [7:0] unused;
    send_frame(8'h1C, 1'b1, 1'b0, 11, -1, 1'b0, unused);
    checks++; if (parity_err !== 1'b1) begin errors++; $display("[TB] FAIL parity_set: got %0b expected 1", parity_err); end
    checks++; if (level !== '0) begin errors++; $display("[TB] FAIL parity_level: got %0d expected 0", level); end
    pulse_clr_err();
    checks++; if (parity_err !== 1'b0) begin errors++; $display("[TB] FAIL parity_clear: got %0b expected 0", parity_err); end
    send_frame(8'h2A, 1'b0, 1'b1, 11, -1, 1'b0, unused);
    checks++; if (frame_err !== 1'b1 || level !== '0) begin
      errors++; $display("[TB] FAIL bad_stop: got frame_err=%0b level=%0d expected 1 0", frame_err, level);
    end
    pulse_clr_err();
  endtask

  task automatic test_overflow();
    logic [7:0] got;
    for (int v = 1; v <= 9; v++) send_good(8'(v));
    checks++; if (level !== 4'(model_level)) begin errors++; $display("[TB] FAIL ovf_level: got %0d expected %0d", level, model_level); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag: got %0b expected 1", overflow); end
    while (exp_q.size() > 0) begin
      pop_one(got);
      checks++; if (got !== exp_q[0]) begin errors++; $display("[TB] FAIL ovf_order: got %02h expected %02h", got, exp_q[0]); end
      void'(exp_q.pop_front());
    end
    checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL ovf_drained: got ready=%0b expected 0", ready); end
    pulse_clr_err();
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_clear: got %0b expected 0", overflow); end
  endtask

  task automatic test_full_pop();
    logic [7:0] got;
    for (int v = 8'h11; v <= 8'h18; v++) send_good(8'(v));
    checks++; if (level !== 4'(DEPTH)) begin errors++; $display("[TB] FAIL full_level: got %0d expected %0d", level, DEPTH); end
    send_frame(8'h19, 1'b0, 1'b0, 11, -1, 1'b1, got);
    checks++; if (got !== exp_q[0]) begin errors++; $display("[TB] FAIL full_pop_head: got %02h expected %02h", got, exp_q[0]); end
    void'(exp_q.pop_front());
    exp_q.push_back(8'h19);
    checks++; if (level !== 4'(DEPTH)) begin errors++; $display("[TB] FAIL full_pop_level: got %0d expected %0d", level, DEPTH); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL full_pop_ovf: got %0b expected 0", overflow); end
    while (exp_q.size() > 0) begin
      pop_one(got);
      checks++; if (got !== exp_q[0]) begin errors++; $display("[TB] FAIL full_pop_order: got %02h expected %02h", got, exp_q[0]); end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_glitch();
    logic [7:0] got;
    send_frame(8'h5A, 1'b0, 1'b0, 11, 3, 1'b0, got);
    exp_q.push_back(8'h5A);
    model_level++;
    checks++; if (level !== 4'(model_level) || parity_err !== 1'b0 || frame_err !== 1'b0) begin
      errors++; $display("[TB] FAIL glitch_status: got level=%0d perr=%0b ferr=%0b expected %0d 0 0", level, parity_err, frame_err, model_level);
    end
    pop_one(got);
    checks++; if (got !== exp_q[0]) begin errors++; $display("[TB] FAIL glitch_data: got %02h expected %02h", got, exp_q[0]); end
    void'(exp_q.pop_front());
  endtask

  task automatic test_timeout();
    logic [7:0] got;
    send_frame(8'h00, 1'b0, 1'b0, 5, -1, 1'b0, got);
    tick(TIMEOUT_CYC - 200);
    checks++; if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL timeout_early: got %0b expected 0", frame_err); end
    tick(300);
    checks++; if (frame_err !== 1'b1 || level !== '0) begin
      errors++; $display("[TB] FAIL timeout_set: got frame_err=%0b level=%0d expected 1 0", frame_err, level);
    end
    pulse_clr_err();
    send_good(8'hF0);
    pop_one(got);
    checks++; if (got !== exp_q[0]) begin errors++; $display("[TB] FAIL after_timeout: got %02h expected %02h", got, exp_q[0]); end
    void'(exp_q.pop_front());
  endtask

  task automatic test_reset_midframe();
    logic [7:0] got;
    send_good(8'h33);
    send_frame(8'h1C, 1'b1, 1'b0, 11, -1, 1'b0, got);
    send_frame(8'h00, 1'b0, 1'b0, 4, -1, 1'b0, got);
    clrn = 1'b0;
    tick(3);
    checks++; if (ready !== 1'b0 || level !== '0 || {overflow, parity_err, frame_err} !== 3'b000) begin
      errors++; $display("[TB] FAIL midframe_reset: got ready=%0b level=%0d flags=%b expected 0 0 000",
                         ready, level, {overflow, parity_err, frame_err});
    end
    clrn = 1'b1;
    exp_q.delete();
    model_level = 0;
    tick(3);
    send_good(8'h42);
    pop_one(got);
    checks++; if (got !== exp_q[0]) begin errors++; $display("[TB] FAIL post_reset_frame: got %02h expected %02h", got, exp_q[0]); end
    void'(exp_q.pop_front());
  endtask

  initial begin
    checks = 0;
    errors = 0;
    model_level = 0;
    test_reset();
    test_clean_frame();
    test_frame_errors();
    test_overflow();
    test_full_pop();
    test_glitch();
    test_timeout();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
